// File: rtl/pipeline_pkg.sv
// Shared pipeline types: fetch/decode buffer entry, state encoding and bubble value.
`timescale 1ns/1ps
package pipeline_pkg;

    localparam int unsigned FD_DATA_W = 32;
    localparam int unsigned FD_ADDR_W = 32;

    // addi x0,x0,0
    localparam logic [FD_DATA_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [FD_DATA_W-1:0] instr;
        logic [FD_ADDR_W-1:0] pc;
        logic [FD_DATA_W-1:0] pcplus4;
    } fd_entry_t;

    typedef enum logic [1:0] {
        FD_EMPTY = 2'd0,
        FD_ONE   = 2'd1,
        FD_FULL  = 2'd2
    } fd_state_t;

endpackage

// File: rtl/fetch_decode_buffer.sv
// Two-entry elastic buffer between fetch and decode with flush support.
// in_ready comes only from registered occupancy, so fetch stalls never see decode's ready.
`timescale 1ns/1ps
module fetch_decode_buffer #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(pipeline_pkg::NOP_INSTR)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    instr_i,
    input  logic [ADDRESS_WIDTH-1:0] pc_i,
    input  logic [DATA_WIDTH-1:0]    pcplus4_i,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    instr_o,
    output logic [ADDRESS_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0]    pcplus4_o
);
    import pipeline_pkg::*;

    fd_state_t state, state_nxt;
    logic      wr_ptr, wr_ptr_nxt;
    logic      rd_ptr, rd_ptr_nxt;
    logic      wr_en;
    fd_entry_t mem [2];
    fd_entry_t entry_in;
    fd_entry_t head;
    logic      push, pop;

    // Handshake qualifiers from registered state only
    always_comb begin
        in_ready  = (state != FD_FULL) && rst;
        out_valid = (state != FD_EMPTY);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        entry_in  = '{instr:   FD_DATA_W'(instr_i),
                      pc:      FD_ADDR_W'(pc_i),
                      pcplus4: FD_DATA_W'(pcplus4_i)};
    end

    // Next-state, pointer and write-enable logic; flush wins over everything
    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        wr_en      = 1'b0;
        if (flush) begin
            state_nxt  = FD_EMPTY;
            wr_ptr_nxt = 1'b0;
            rd_ptr_nxt = 1'b0;
        end else begin
            if (push) begin
                wr_en      = 1'b1;
                wr_ptr_nxt = ~wr_ptr;
            end
            if (pop) begin
                rd_ptr_nxt = ~rd_ptr;
            end
            case (state)
                FD_EMPTY: if (push) state_nxt = FD_ONE;
                FD_ONE: begin
                    if (push && !pop)      state_nxt = FD_FULL;
                    else if (!push && pop) state_nxt = FD_EMPTY;
                end
                FD_FULL:  if (pop) state_nxt = FD_ONE;
                default:  state_nxt = FD_EMPTY;
            endcase
        end
    end

    // State, pointers and storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= FD_EMPTY;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            state  <= state_nxt;
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            if (wr_en) begin
                mem[wr_ptr] <= entry_in;
            end
        end
    end

    // Head entry to decode, bubble when empty
    always_comb begin
        head = mem[rd_ptr];
        if (out_valid) begin
            instr_o   = DATA_WIDTH'(head.instr);
            pc_o      = ADDRESS_WIDTH'(head.pc);
            pcplus4_o = DATA_WIDTH'(head.pcplus4);
        end else begin
            instr_o   = NOP_INSTR;
            pc_o      = '0;
            pcplus4_o = '0;
        end
    end

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Self-checking bench for fetch_decode_buffer: directed scenarios plus a randomized run against a queue model.
`timescale 1ns/1ps
module tb_fetch_decode_buffer;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic [31:0] pcplus4_i;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pcplus4_o;

    int checks;
    int failures;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcplus4;
    } item_t;

    item_t model_q[$];

    fetch_decode_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr_i   (instr_i),
        .pc_i      (pc_i),
        .pcplus4_i (pcplus4_i),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr_o   (instr_o),
        .pc_o      (pc_o),
        .pcplus4_o (pcplus4_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one fetched instruction; the instruction word is derived from the PC so it is recognisable
    task automatic drive(input logic v, input logic [31:0] pc);
        in_valid  = v;
        pc_i      = pc;
        pcplus4_i = pc + 32'd4;
        instr_i   = 32'hA500_0000 ^ pc;
    endtask

    // Advance one clock; the queue model applies the buffer rules on the same edge
    task automatic tick();
        bit   can_push;
        bit   do_push;
        bit   do_pop;
        item_t it;
        @(posedge clk);
        can_push = rst && (model_q.size() < 2);
        do_push  = in_valid && can_push;
        do_pop   = (model_q.size() > 0) && out_ready;
        if (!rst || flush) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                it.instr   = instr_i;
                it.pc      = pc_i;
                it.pcplus4 = pcplus4_i;
                model_q.push_back(it);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        instr_i = '0; pc_i = '0; pcplus4_i = '0;
        #2;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (instr_o !== NOP) begin failures++; $display("FAIL reset_instr got=%h exp=%h", instr_o, NOP); end
        checks++; if (pc_o !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", pc_o); end
        checks++; if (pcplus4_o !== 32'h0) begin failures++; $display("FAIL reset_pcplus4 got=%h exp=0", pcplus4_o); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
        tick();
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_streaming();
        logic [31:0] pcs [3];
        pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, pcs[i]);
            tick();
            checks++; if (out_valid !== 1'b1 || pc_o !== pcs[i]) begin failures++; $display("FAIL stream_pc[%0d] got=%h/%0b exp=%h/1", i, pc_o, out_valid, pcs[i]); end
            checks++; if (pcplus4_o !== pcs[i] + 32'd4) begin failures++; $display("FAIL stream_pcplus4[%0d] got=%h exp=%h", i, pcplus4_o, pcs[i] + 32'd4); end
            checks++; if (instr_o !== (32'hA500_0000 ^ pcs[i])) begin failures++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, instr_o, 32'hA500_0000 ^ pcs[i]); end
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready[%0d] got=%0b exp=1", i, in_ready); end
        end
        drive(1'b0, 32'h0);
        tick();
        checks++; if (out_valid !== 1'b0 || instr_o !== NOP) begin failures++; $display("FAIL stream_drain got=%0b/%h exp=0/%h", out_valid, instr_o, NOP); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 32'h10); tick();
        checks++; if (in_ready !== 1'b1 || pc_o !== 32'h10) begin failures++; $display("FAIL bp_one got=%0b/%h exp=1/10", in_ready, pc_o); end
        drive(1'b1, 32'h14); tick();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_in_ready got=%0b exp=0", in_ready); end
        drive(1'b1, 32'h18); tick();
        checks++; if (pc_o !== 32'h10 || out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold got=%h/%0b/%0b exp=10/1/0", pc_o, out_valid, in_ready); end
        out_ready = 1'b1;
        tick();
        checks++; if (pc_o !== 32'h14) begin failures++; $display("FAIL bp_second got=%h exp=14", pc_o); end
        tick();
        checks++; if (pc_o !== 32'h18 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_third got=%h/%0b exp=18/1", pc_o, out_valid); end
        drive(1'b0, 32'h0); tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_push_pop_one();
        out_ready = 1'b0;
        drive(1'b1, 32'h20); tick();
        checks++; if (pc_o !== 32'h20) begin failures++; $display("FAIL pp_first got=%h exp=20", pc_o); end
        out_ready = 1'b1;
        drive(1'b1, 32'h24); tick();
        checks++; if (pc_o !== 32'h24 || out_valid !== 1'b1 || in_ready !== 1'b1) begin failures++; $display("FAIL pp_swap got=%h/%0b/%0b exp=24/1/1", pc_o, out_valid, in_ready); end
        drive(1'b0, 32'h0); tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL pp_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 32'h30); tick();
        drive(1'b1, 32'h34); tick();
        flush = 1'b1;
        drive(1'b1, 32'h38);
        tick();
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0 || instr_o !== NOP || pc_o !== 32'h0) begin failures++; $display("FAIL flush_full got=%0b/%h/%h exp=0/%h/0", out_valid, instr_o, pc_o, NOP); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%0b exp=1", in_ready); end
        drive(1'b1, 32'h100); tick();
        checks++; if (out_valid !== 1'b1 || pc_o !== 32'h100) begin failures++; $display("FAIL flush_next_head got=%0b/%h exp=1/100", out_valid, pc_o); end
        // Flush in ONE discards the same-cycle push too
        flush = 1'b1;
        drive(1'b1, 32'h104);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_one_push got=%0b exp=0", out_valid); end
        out_ready = 1'b1;
        drive(1'b1, 32'h200); tick();
        drive(1'b0, 32'h0);
        checks++; if (pc_o !== 32'h200) begin failures++; $display("FAIL flush_ptr_restart got=%h exp=200", pc_o); end
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(1'b1, 32'h40); tick();
        drive(1'b1, 32'h44); tick();
        drive(1'b0, 32'h0);
        #2 rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || instr_o !== NOP || pc_o !== 32'h0 || in_ready !== 1'b0) begin failures++; $display("FAIL midreset got=%0b/%h/%h/%0b exp=0/%h/0/0", out_valid, instr_o, pc_o, in_ready, NOP); end
        tick();
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL midreset_release got=%0b/%0b exp=1/0", in_ready, out_valid); end
        out_ready = 1'b1;
        drive(1'b1, 32'h48); tick();
        drive(1'b0, 32'h0);
        checks++; if (pc_o !== 32'h48) begin failures++; $display("FAIL midreset_push got=%h exp=48", pc_o); end
        tick();
    endtask

    task automatic test_random();
        logic        rdy_a;
        logic        rdy_b;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
        logic [31:0] exp_p4;
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            instr_i   = $urandom;
            pc_i      = $urandom;
            pcplus4_i = pc_i + 32'd4;
            flush     = ($urandom_range(0, 19) == 0);
            out_ready = 1'b0; #1 rdy_a = in_ready;
            out_ready = 1'b1; #1 rdy_b = in_ready;
            out_ready = ($urandom_range(0, 9) < 6);
            #1;
            checks++; if (rdy_a !== rdy_b || rdy_a !== (model_q.size() < 2)) begin failures++; $display("FAIL rnd_in_ready cyc=%0d got=%0b/%0b exp=%0b", c, rdy_a, rdy_b, model_q.size() < 2); end
            exp_valid = (model_q.size() > 0);
            exp_instr = exp_valid ? model_q[0].instr   : NOP;
            exp_pc    = exp_valid ? model_q[0].pc      : 32'h0;
            exp_p4    = exp_valid ? model_q[0].pcplus4 : 32'h0;
            checks++; if (out_valid !== exp_valid || instr_o !== exp_instr || pc_o !== exp_pc || pcplus4_o !== exp_p4) begin
                failures++;
                $display("FAIL rnd_head cyc=%0d got=%0b/%h/%h/%h exp=%0b/%h/%h/%h", c, out_valid, instr_o, pc_o, pcplus4_o, exp_valid, exp_instr, exp_pc, exp_p4);
            end
            tick();
        end
        drive(1'b0, 32'h0);
        flush = 1'b0;
        out_ready = 1'b1;
        tick(); tick();
        checks++; if (out_valid !== 1'b0 || model_q.size() != 0) begin failures++; $display("FAIL rnd_drain got=%0b exp=0", out_valid); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_push_pop_one();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_decode_buffer.md
# fetch_decode_buffer

Two-entry elastic buffer between the fetch stage and the decode stage. It captures each fetched instruction with its PC and PCPlus4, and hands them to decode through a valid/ready handshake. A fetch-side stall never combinationally depends on decode's ready. A `flush` input squashes in-flight instructions on a taken branch or jump.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of `instr` and `PCPlus4`
- `ADDRESS_WIDTH`, 32, width of `PC`
- `NOP_INSTR`, 32'h0000_0013, bubble value (`addi x0,x0,0`) driven when no entry is valid

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  fetch presents a valid instruction
- `in_ready`  out  1  buffer can accept this cycle
- `instr_i`  in  DATA_WIDTH  fetched instruction
- `pc_i`  in  ADDRESS_WIDTH  PC of `instr_i`
- `pcplus4_i`  in  DATA_WIDTH  PC+4 of `instr_i`
- `flush`  in  1  squash all held and incoming entries
- `out_valid`  out  1  head entry valid for decode
- `out_ready`  in  1  decode consumes the head this cycle
- `instr_o`  out  DATA_WIDTH  head instruction, or `NOP_INSTR` when empty
- `pc_o`  out  ADDRESS_WIDTH  head PC, or 0 when empty
- `pcplus4_o`  out  DATA_WIDTH  head PC+4, or 0 when empty

## Operation
- **Storage:** two-entry ring of {instr, pc, pcplus4}.
  - 1-bit `wr_ptr` and `rd_ptr`.
  - State EMPTY / ONE / FULL, encoded as a 2-bit count.
- **Handshakes:**
  - push = `in_valid && in_ready`.
  - pop = `out_valid && out_ready`.
- **Ready and valid:**
  - `in_ready` = (state != FULL) && `rst` high. It is derived only from registered state, so there is no path from `out_ready`.
  - `out_valid` = (state != EMPTY).
- **Outputs:** `instr_o`/`pc_o`/`pcplus4_o` = entry[`rd_ptr`] when valid; otherwise NOP/0/0.
- **Transitions (flush low):**
  - EMPTY: push → ONE. Pop is impossible.
  - ONE: push & !pop → FULL. !push & pop → EMPTY. Push & pop → ONE, with the new entry written at `wr_ptr` and `rd_ptr` advanced.
  - FULL: push is impossible. Pop → ONE.
- **Flush:** has highest priority. Next state is EMPTY and `wr_ptr`/`rd_ptr` return to 0.
  - A same-cycle push is discarded.
  - A same-cycle pop is still considered accepted by decode.
  - Stored payloads need not be cleared, but outputs show NOP/0 because state is EMPTY.
- **Pointers:** wrap modulo 2. `rd_ptr` and `wr_ptr` toggle on pop and push respectively.
- **Payload:** passes through unmodified. No arithmetic is performed on PC.

## Timing
- **Reset (`rst` low, asynchronous):**
  - state EMPTY, both pointers 0.
  - `out_valid`=0, `instr_o`=NOP_INSTR, `pc_o`=0, `pcplus4_o`=0.
  - `in_ready`=0 while `rst` is low; `in_ready`=1 in the first cycle after release.
- **Latency:** 1 cycle. An entry pushed at edge N is visible on the outputs, with `out_valid`=1, after edge N.
- **Throughput:** 1 instruction/cycle sustained when `out_ready` is held high.
- **Stall recovery:** when `out_ready` deasserts, up to 2 entries are absorbed. `in_ready` falls the cycle after state reaches FULL.
- **Output stability:** outputs hold stable while `out_valid && !out_ready`.
- **Flush:** at edge N, `out_valid`=0 after N. A push at N+1 is accepted normally.
- **Reset mid-operation:** all entries are lost immediately and the block behaves as after reset; no partial state survives.

## Structure
- Shared package `pipeline_pkg` holds:
  - `NOP_INSTR`.
  - The packed struct `fd_entry_t` {instr, pc, pcplus4}.
  - The enum `fd_state_t` {FD_EMPTY, FD_ONE, FD_FULL}.
- `fetch_top` keeps its own outputs; this block is instantiated alongside it in the core top.
- No sub-module: storage, pointers and state live in a single `always_ff` plus output muxing.

## Test plan
- **Reset:** `rst` low mid-stream → `out_valid`=0, `instr_o`=32'h00000013, `pc_o`=0, `in_ready`=0. After release → `in_ready`=1.
- **Streaming:** `out_ready`=1, push PC 0x0,0x4,0x8 on consecutive cycles → decode sees `pc_o` 0x0,0x4,0x8 one cycle later each, `pcplus4_o` 0x4,0x8,0xC.
- **Backpressure:** `out_ready`=0, push 0x10,0x14,0x18 → first two accepted, `in_ready`=0, 0x18 held by fetch. `out_ready`=1 → outputs 0x10,0x14,0x18 in order with no loss or duplication.
- **Simultaneous push/pop in ONE:** holding 0x20, push 0x24 while popping → state stays ONE, `pc_o`=0x24 next cycle.
- **Flush in FULL with concurrent push:** → `out_valid`=0 next cycle, `instr_o`=NOP. Next push 0x100 appears as head.
- **Random:** random `in_valid`/`out_ready`/`flush` for 10k cycles → scoreboard matches order. `in_ready` never depends combinationally on `out_ready`.
